neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

Sequential multiply-accumulate back end for one neuron of the handwritten-digit recognition datapath. It consumes a stream of signed 19-bit weighted terms, one per handshake. These are the same operand width the 19-bit pairwise adders use. The block accumulates N_INPUTS terms in a widened register, adds a bias, then scales, activates and saturates the sum. It sits directly downstream of the product/adder stage and feeds the layer output buffer.

## Interface
- N_INPUTS, 784: terms per neuron (≥2).
- IN_W, 19: width of signed term and bias.
- ACC_W, 30: accumulator width. Must be ≥ IN_W + ceil(log2(N_INPUTS+1)), so the accumulator never overflows internally.
- SHIFT, 8: arithmetic right shift applied before saturation (fixed-point rescale).
- OUT_W, 16: output width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a term this cycle.
- in_data  input  IN_W  signed term.
- bias  input  IN_W  signed bias. Sampled in the BIAS cycle only.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_W  signed (two's complement) result.
- out_sat  output  1  result was clamped. Qualified by out_valid.

## Operation
- States: ACC, BIAS, OUT. Reset state is ACC, with acc=0 and cnt=0.
- ACC:
  - in_ready=1.
  - On in_valid&&in_ready: acc += sign-extended in_data, and cnt += 1.
  - If the accepted term is the N_INPUTS-th (cnt==N_INPUTS-1 before the increment), go to BIAS.
- BIAS:
  - in_ready=0.
  - acc += sign-extended bias, then go to OUT. Always exactly one cycle.
- OUT:
  - in_ready=0 and out_valid=1.
  - out_data and out_sat are registered on entry to OUT and held stable until the handshake.
  - On out_ready, go to ACC with acc=0 and cnt=0.
- Result computation:
  - s = acc >>> SHIFT, arithmetic shift with truncation toward −∞.
  - s is clamped to the range of OUT_W as defined under Configuration.
  - out_sat=1 if and only if the clamp changed the value.
- Arithmetic:
  - All sums are full ACC_W two's complement.
  - in_data and bias are sign-extended from IN_W.
  - No internal wrap is possible at legal parameter values.
- Boundary conditions:
  - in_valid with in_ready=0 has no effect and the term is not consumed. The upstream stage must hold it.
  - out_ready while out_valid=0 is ignored.
  - A gap in in_valid pauses accumulation; cnt is held.
  - rst at any point, including mid-frame or while in OUT, discards the partial sum. The next cycle is ACC with acc=0, cnt=0 and out_valid=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0.
- Last term accepted at edge T:
  - BIAS occupies cycle T+1.
  - out_valid is high from T+2.
- Output handshake at edge U: out_valid is low and in_ready is high from U+1. There is no same-cycle bypass to the next frame.
- Peak throughput: one neuron per N_INPUTS+2 cycles.
- out_data, out_valid and out_sat are driven directly from registers; there is no combinational path from the inputs.

## Configuration
- NEURON_RELU_EN defined:
  - ReLU is applied before clamping: negative s becomes 0.
  - out_data range is [0, 2^(OUT_W-1)−1].
  - out_sat is set only on positive overflow. Negative-to-zero is activation, not saturation, so out_sat=0 in that case.
- NEURON_RELU_EN undefined:
  - Signed saturation to [−2^(OUT_W-1), 2^(OUT_W-1)−1].
  - out_sat is set on either overflow.

## Test plan
Bench overrides: N_INPUTS=4, SHIFT=0, OUT_W=16 unless stated.
- Basic frame:
  - Stimulus: terms 100, 200, 300, 400 on consecutive cycles; bias=−50; out_ready=1.
  - Required: out_data=950 and out_sat=0; out_valid asserts 2 cycles after the 4th accept and lasts one cycle.
- Negative sum:
  - Stimulus: terms −1000 ×4; bias=0.
  - Required: out_data=0 with the macro, out_data=−4000 without; out_sat=0 in both builds.
- Saturation:
  - Stimulus: terms 262143 ×4; bias=262143.
  - Required: out_data=32767 and out_sat=1.
  - Also, without the macro: terms −262144 ×4 must give out_data=−32768 and out_sat=1.
- Backpressure and gaps:
  - Stimulus: in_valid toggled 1,0,1,0,…; out_ready held low for 5 cycles.
  - Required: in_ready=0 throughout BIAS and OUT; out_data stable while held; the next frame accepts its first term the cycle after the output handshake.
- Shift:
  - Stimulus: SHIFT=8; terms 256, 256, 256, −1; bias=0.
  - Required: out_data=2 (767>>>8).
- Reset mid-frame:
  - Stimulus: 2 terms of 500, pulse rst, then a full frame of 1,1,1,1 with bias=0.
  - Required: out_data=4, so the first two terms are discarded; all outputs hold their reset values in the cycle after rst.

Source files
------------

// File: rtl/neuron_accumulator_if.sv
// Handshake bundle for the neuron accumulator: term stream in, scaled result out.
// The block connects through the slave modport; the producer/consumer side uses master.
interface neuron_accumulator_if #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [IN_W-1:0]  bias;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid, in_data, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/neuron_accumulator.sv
// Sequential neuron back end: accumulate N_INPUTS signed terms, add bias, shift, clamp.
// Define NEURON_RELU_EN to apply ReLU before clamping (negative results become 0, unflagged).
module neuron_accumulator #(
    parameter int N_INPUTS = 784,
    parameter int IN_W     = 19,
    parameter int ACC_W    = 30,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 16
) (
    input logic clk,
    input logic rst,
    neuron_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {ACC, BIAS, OUT} state_t;

    state_t                   state_reg, state_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic                     out_valid_reg, out_valid_next;
    logic [OUT_W-1:0]         out_data_reg, out_data_next;
    logic                     out_sat_reg, out_sat_next;

    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  biased;
    logic signed [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]         res_data;
    logic                     res_sat;

    assign in_ext   = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    assign bias_ext = {{(ACC_W-IN_W){bus.bias[IN_W-1]}}, bus.bias};
    assign biased   = acc_reg + bias_ext;
    assign shifted  = biased >>> SHIFT;

    // Result is formed from the bias-adjusted sum during BIAS and captured on entry to OUT.
    always_comb begin
        res_data = shifted[OUT_W-1:0];
        res_sat  = 1'b0;
        if (shifted > OUT_MAX) begin
            res_data = OUT_MAX[OUT_W-1:0];
            res_sat  = 1'b1;
        end
`ifdef NEURON_RELU_EN
        else if (shifted < 0) begin
            res_data = '0;
            res_sat  = 1'b0;
        end
`else
        else if (shifted < OUT_MIN) begin
            res_data = OUT_MIN[OUT_W-1:0];
            res_sat  = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_sat_next   = out_sat_reg;
        case (state_reg)
            ACC: begin
                if (bus.in_valid) begin
                    acc_next = acc_reg + in_ext;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = BIAS;
                    end
                end
            end
            BIAS: begin
                acc_next       = biased;
                out_valid_next = 1'b1;
                out_data_next  = res_data;
                out_sat_next   = res_sat;
                state_next     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    acc_next       = '0;
                    cnt_next       = '0;
                    out_valid_next = 1'b0;
                    state_next     = ACC;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACC;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sat_reg   <= out_sat_next;
        end
    end

    assign bus.in_ready  = (state_reg == ACC);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sat   = out_sat_reg;
endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: directed frames with literal results plus randomized traffic,
// all checked every cycle against a sum-based model (two DUTs: SHIFT=0 and SHIFT=8).
module tb_neuron_accumulator;
    localparam int N     = 4;
    localparam int IN_W  = 19;
    localparam int OUT_W = 16;
    localparam int ACC_W = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid;
    logic            out_ready;
    logic [IN_W-1:0] in_data;
    logic [IN_W-1:0] bias;

    neuron_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if0 ();
    neuron_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if1 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.bias      = bias;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.bias      = bias;
    assign if1.out_ready = out_ready;

    neuron_accumulator #(.N_INPUTS(N), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(0), .OUT_W(OUT_W)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    neuron_accumulator #(.N_INPUTS(N), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(8), .OUT_W(OUT_W)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Result rule: floor shift, optional ReLU, clamp to OUT_W signed range.
    function automatic void calc(input longint sum, input int sh, output longint d, output longint s);
        longint v;
        longint lo;
        v = sum >>> sh;
`ifdef NEURON_RELU_EN
        if (v < 0) v = 0;
        lo = 0;
`else
        lo = -32768;
`endif
        if (v > 32767) begin d = 32767; s = 1; end
        else if (v < lo) begin d = lo; s = 1; end
        else begin d = v; s = 0; end
    endfunction

    // Model: collect N accepted terms, one bias cycle, then hold the result until out_ready.
    bit     model_on = 0;
    bit     accepting, bias_next, exp_valid, post_rst;
    int     n_acc;
    longint sum, e0, e1, es0, es1;

    always @(negedge clk) begin
        if (model_on) begin
            check("in_ready0", if0.in_ready, accepting);
            check("in_ready1", if1.in_ready, accepting);
            check("out_valid0", if0.out_valid, exp_valid);
            check("out_valid1", if1.out_valid, exp_valid);
            if (exp_valid || post_rst) begin
                check("out_data0", $signed(if0.out_data), e0);
                check("out_sat0", if0.out_sat, es0);
                check("out_data1", $signed(if1.out_data), e1);
                check("out_sat1", if1.out_sat, es1);
            end
        end
        post_rst = 0;
        if (rst) begin
            model_on = 1; accepting = 1; bias_next = 0; exp_valid = 0; post_rst = 1;
            n_acc = 0; sum = 0; e0 = 0; e1 = 0; es0 = 0; es1 = 0;
        end else if (model_on) begin
            if (accepting) begin
                if (in_valid) begin
                    sum += longint'($signed(in_data));
                    n_acc++;
                    if (n_acc == N) begin
                        accepting = 0;
                        bias_next = 1;
                    end
                end
            end else if (bias_next) begin
                sum += longint'($signed(bias));
                calc(sum, 0, e0, es0);
                calc(sum, 8, e1, es1);
                bias_next = 0;
                exp_valid = 1;
            end else if (exp_valid && out_ready) begin
                exp_valid = 0; accepting = 1; n_acc = 0; sum = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_term(input int v);
        bit got = 0;
        in_valid = 1'b1;
        in_data  = IN_W'(v);
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = if0.in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!got) timeout("term_accept");
    endtask

    task automatic send_frame(input int t[4], input int b, input bit gaps);
        bias = IN_W'(b);
        for (int i = 0; i < 4; i++) begin
            send_term(t[i]);
            if (gaps) tick();
        end
    endtask

    task automatic get_result(input string name, input longint d0, input longint s0,
                              input longint d1, input longint s1, input int hold);
        bit found = 0;
        out_ready = (hold == 0);
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = if0.out_valid;
        end
        if (!found) begin
            timeout({name, "_valid"});
            out_ready = 1'b0;
            return;
        end
        check({name, "_data0"}, $signed(if0.out_data), d0);
        check({name, "_sat0"}, if0.out_sat, s0);
        check({name, "_data1"}, $signed(if1.out_data), d1);
        check({name, "_sat1"}, if1.out_sat, s1);
        $display("frame %s data0=%0d sat0=%0b data1=%0d sat1=%0b", name,
                 $signed(if0.out_data), if0.out_sat, $signed(if1.out_data), if1.out_sat);
        tick();
        if (hold > 0) begin
            repeat (hold) tick();
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
    endtask

    function automatic logic [IN_W-1:0] rnd_term();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 19'sh3FFFF;
        if (r == 1) return 19'sh40000;
        return IN_W'($urandom);
    endfunction

    initial begin
        longint d, s;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; bias = '0;
        tick(); tick();
        rst = 1'b0;

        calc(950, 0, d, s);      check("model_basic", d, 950);
        calc(1310715, 0, d, s);  check("model_sat", s, 1);
        calc(767, 8, d, s);      check("model_shift", d, 2);
`ifdef NEURON_RELU_EN
        calc(-4000, 0, d, s);    check("model_neg", d, 0);
`else
        calc(-1048576, 0, d, s); check("model_negsat", d, -32768);
`endif

        send_frame('{100, 200, 300, 400}, -50, 1'b0);
        get_result("basic", 950, 0, 3, 0, 0);

        send_frame('{-1000, -1000, -1000, -1000}, 0, 1'b0);
`ifdef NEURON_RELU_EN
        get_result("negative", 0, 0, 0, 0, 0);
`else
        get_result("negative", -4000, 0, -16, 0, 0);
`endif

        send_frame('{262143, 262143, 262143, 262143}, 262143, 1'b0);
        get_result("sat_pos", 32767, 1, 5119, 0, 0);

        send_frame('{-262144, -262144, -262144, -262144}, 0, 1'b0);
`ifdef NEURON_RELU_EN
        get_result("sat_neg", 0, 0, 0, 0, 0);
`else
        get_result("sat_neg", -32768, 1, -4096, 0, 0);
`endif

        send_frame('{10, 20, 30, 40}, 5, 1'b1);
        get_result("backpressure", 105, 0, 0, 0, 5);

        send_frame('{256, 256, 256, -1}, 0, 1'b0);
        get_result("shift", 767, 0, 2, 0, 0);

        send_term(500);
        send_term(500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_frame('{1, 1, 1, 1}, 0, 1'b0);
        get_result("reset_mid", 4, 0, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd_term();
            bias      = rnd_term();
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
